exe_issue_ctrl: RTL and testbench
=================================

# exe_issue_ctrl

Pipeline sequencing controller for the ID→EXE boundary. It generates the write-enable and flush strobes for the PC, ID and EXE pipeline registers, and owns the occupancy FSM of the shared multi-cycle multiply/divide unit (MDU). It resolves exception flush, memory-stage stall, MDU occupancy and load-use hazards in a fixed priority order. It sits beside the EXE stage register and drives that register's `EXE_Wr`/`EXE_Flush` inputs.

## Interface
- `DIV_CYCLES`, 32: MDU divide latency in cycles; must be ≥1.
- `MUL_CYCLES`, 2: MDU multiply latency in cycles; must be ≥1.

- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: reset; asynchronous, active-low.
- `Exc_Flush` input 1: MEM-stage exception or ERET commit; flushes younger stages.
- `MEM_Stall` input 1: data-cache miss or other MEM backpressure.
- `EXE_MDUReq` input 1: the instruction in EXE needs the MDU.
- `EXE_MDUIsDiv` input 1: 1 = divide, 0 = multiply; valid with `EXE_MDUReq`.
- `EXE_IsLoad` input 1: the instruction in EXE is a load.
- `EXE_rt` input 5: load destination register.
- `ID_rs`, `ID_rt` input 5 each: ID-stage source registers.
- `ID_ReadsRs`, `ID_ReadsRt` input 1 each: the ID instruction really reads that source.
- `PC_Wr`, `ID_Wr`, `EXE_Wr` output 1 each: stage register write enables.
- `ID_Flush`, `EXE_Flush` output 1 each: stage register flush strobes.
- `MDU_Start` output 1: one-cycle pulse that launches the MDU operation.
- `MDU_Flush` output 1: one-cycle abort pulse to the MDU.
- `MDU_Busy` output 1: the MDU is computing.

## Operation
- State: FSM {IDLE, BUSY, DONE, FLUSH}, plus a down-counter `cnt` of width `$clog2(max(DIV_CYCLES,MUL_CYCLES))+1`.
- Default outputs: all write enables 1, all flushes and pulses 0.
- Priority, highest first: `Exc_Flush` > `MEM_Stall` > MDU stall > load-use.
- `Exc_Flush`=1:
  - Outputs: `ID_Flush`=`EXE_Flush`=1; `PC_Wr`=`ID_Wr`=`EXE_Wr`=1.
  - FSM: BUSY or DONE → FLUSH; otherwise → IDLE.
  - No `MDU_Start`, even if `EXE_MDUReq`=1.
  - Overrides `MEM_Stall`.
- `MEM_Stall`=1 (and no `Exc_Flush`):
  - Outputs: `PC_Wr`=`ID_Wr`=`EXE_Wr`=0; no flushes.
  - The BUSY counter keeps counting.
  - No MDU start occurs.
- IDLE:
  - Transition condition: `EXE_MDUReq`=1 with no `Exc_Flush`/`MEM_Stall`.
  - Action: `MDU_Start`=1; `cnt` ← (`EXE_MDUIsDiv` ? `DIV_CYCLES` : `MUL_CYCLES`) − 1; → BUSY.
  - Stall in this cycle: `PC_Wr`=`ID_Wr`=`EXE_Wr`=0.
- BUSY:
  - Outputs: `MDU_Busy`=1; PC/ID/EXE writes held at 0.
  - `cnt` decrements each cycle; when `cnt`==0 → DONE.
- DONE:
  - Result is valid and the stall is released (writes 1 unless overridden).
  - → IDLE on the first cycle with `EXE_Wr`=1; stays in DONE while `MEM_Stall`=1.
  - This prevents the same EXE instruction from restarting the MDU.
- FLUSH: `MDU_Flush`=1 for exactly one cycle, → IDLE; `EXE_MDUReq` is ignored in this state.
- Load-use hazard:
  - Condition: `EXE_IsLoad` && `EXE_rt`≠0 && ((`EXE_rt`==`ID_rs` && `ID_ReadsRs`) || (`EXE_rt`==`ID_rt` && `ID_ReadsRt`)).
  - Action: `PC_Wr`=`ID_Wr`=0, `EXE_Wr`=1, `EXE_Flush`=1 (inserts a bubble).
  - Applies only when no higher-priority condition is active.

## Timing
- Reset (`rst`=0), asynchronous: state=IDLE, `cnt`=0.
- Outputs are combinational from state and inputs. With quiescent inputs during reset: `PC_Wr`=`ID_Wr`=`EXE_Wr`=1, all other outputs 0.
- MDU op of latency N, no interference:
  - `MDU_Start` at cycle t, BUSY during t+1..t+N, DONE at t+N+1.
  - Total stall is N+1 cycles (t..t+N); EXE advances at the end of t+N+1.
- `Exc_Flush` during BUSY at cycle k: FLUSH at k+1 (`MDU_Flush`=1), IDLE at k+2.
- `Exc_Flush` in the same cycle as an IDLE request: no start; stays IDLE.
- Reset mid-BUSY: returns to IDLE immediately. No `MDU_Flush` pulse; the MDU is reset by the same `rst`.
- Load-use: one bubble per hazard; the hazard clears the next cycle once the load has moved to MEM.

## Configuration
- `EXE_LOADUSE_STALL_EN`:
  - Defined: load-use detection is compiled in as described above.
  - Undefined: detection logic is absent, and the load-use condition is treated as constant 0 (forwarding from MEM is then required).
- MDU and flush behaviour is identical in both builds.

## Test plan
- Reset released with idle inputs → `PC_Wr`=`ID_Wr`=`EXE_Wr`=1, flushes 0, state IDLE.
- `EXE_MDUReq`=1, `EXE_MDUIsDiv`=1, `DIV_CYCLES`=32 → `MDU_Start` pulse at t; `EXE_Wr`=0 for 33 cycles; `MDU_Busy`=1 for 32 cycles; `EXE_Wr`=1 at t+33; no second `MDU_Start`.
- Multiply (`MUL_CYCLES`=2) with `MEM_Stall`=1 asserted during DONE for 3 cycles → FSM stays DONE and `EXE_Wr`=0 for those 3 cycles; IDLE the cycle after `MEM_Stall` drops; exactly one `MDU_Start`.
- Divide, then `Exc_Flush`=1 at BUSY cycle 10 → `ID_Flush`=`EXE_Flush`=1 that cycle; `MDU_Flush`=1 the next cycle only; then IDLE.
- Load-use: `EXE_IsLoad`=1, `EXE_rt`=5, `ID_rs`=5, `ID_ReadsRs`=1 → `PC_Wr`=`ID_Wr`=0, `EXE_Flush`=1 with the macro defined; all writes 1 and no flush without it; `EXE_rt`=0 never stalls.
- `Exc_Flush`=1 and `MEM_Stall`=1 simultaneously → flushes asserted and all writes 1.

Source files
------------

// File: rtl/exe_issue_ctrl.sv
// ID->EXE pipeline sequencing: stage write/flush strobes plus the MDU occupancy FSM.
// Optional macro EXE_LOADUSE_STALL_EN compiles in load-use bubble insertion.
module exe_issue_ctrl #(
  parameter int DIV_CYCLES = 32,
  parameter int MUL_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Exc_Flush,
  input  logic       MEM_Stall,
  input  logic       EXE_MDUReq,
  input  logic       EXE_MDUIsDiv,
  input  logic       EXE_IsLoad,
  input  logic [4:0] EXE_rt,
  input  logic [4:0] ID_rs,
  input  logic [4:0] ID_rt,
  input  logic       ID_ReadsRs,
  input  logic       ID_ReadsRt,
  output logic       PC_Wr,
  output logic       ID_Wr,
  output logic       EXE_Wr,
  output logic       ID_Flush,
  output logic       EXE_Flush,
  output logic       MDU_Start,
  output logic       MDU_Flush,
  output logic       MDU_Busy
);

  localparam int MAX_CYCLES = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE, S_FLUSH} state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               load_use;
  logic               mdu_stall;

`ifdef EXE_LOADUSE_STALL_EN
  always_comb begin
    load_use = EXE_IsLoad && (EXE_rt != 5'd0) &&
               (((EXE_rt == ID_rs) && ID_ReadsRs) || ((EXE_rt == ID_rt) && ID_ReadsRt));
  end
`else
  // Hazard inputs are unused here; forwarding from MEM covers load-use.
  logic unused_loaduse;
  assign unused_loaduse = ^{EXE_IsLoad, EXE_rt, ID_rs, ID_rt, ID_ReadsRs, ID_ReadsRt};
  assign load_use = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (Exc_Flush) begin
      state_next = ((state_reg == S_BUSY) || (state_reg == S_DONE)) ? S_FLUSH : S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (EXE_MDUReq && !MEM_Stall) begin
            state_next = S_BUSY;
            cnt_next   = EXE_MDUIsDiv ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MUL_CYCLES - 1);
          end
        end
        // The count runs regardless of MEM_Stall: the MDU keeps computing.
        S_BUSY: begin
          if (cnt_reg == '0) state_next = S_DONE;
          else               cnt_next   = cnt_reg - 1'b1;
        end
        S_DONE:  if (EXE_Wr) state_next = S_IDLE;
        S_FLUSH: state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    PC_Wr     = 1'b1;
    ID_Wr     = 1'b1;
    EXE_Wr    = 1'b1;
    ID_Flush  = 1'b0;
    EXE_Flush = 1'b0;
    mdu_stall = ((state_reg == S_IDLE) && EXE_MDUReq) || (state_reg == S_BUSY);
    MDU_Start = (state_reg == S_IDLE) && EXE_MDUReq && !Exc_Flush && !MEM_Stall;
    MDU_Flush = (state_reg == S_FLUSH);
    MDU_Busy  = (state_reg == S_BUSY);
    if (Exc_Flush) begin
      ID_Flush  = 1'b1;
      EXE_Flush = 1'b1;
    end else if (MEM_Stall || mdu_stall) begin
      PC_Wr  = 1'b0;
      ID_Wr  = 1'b0;
      EXE_Wr = 1'b0;
    end else if (load_use) begin
      PC_Wr     = 1'b0;
      ID_Wr     = 1'b0;
      EXE_Flush = 1'b1;
    end
  end

endmodule

// File: tb/tb_exe_issue_ctrl.sv
// Scoreboard bench for exe_issue_ctrl: stimulus pushes hand-computed outputs, a monitor compares.
module tb_exe_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       Exc_Flush, MEM_Stall, EXE_MDUReq, EXE_MDUIsDiv, EXE_IsLoad;
  logic [4:0] EXE_rt, ID_rs, ID_rt;
  logic       ID_ReadsRs, ID_ReadsRt;
  logic       PC_Wr, ID_Wr, EXE_Wr, ID_Flush, EXE_Flush, MDU_Start, MDU_Flush, MDU_Busy;

  // Output vector order: {PC_Wr,ID_Wr,EXE_Wr,ID_Flush,EXE_Flush,MDU_Start,MDU_Flush,MDU_Busy}
  localparam logic [7:0] V_IDLE  = 8'hE0;
  localparam logic [7:0] V_START = 8'h04;
  localparam logic [7:0] V_BUSY  = 8'h01;
  localparam logic [7:0] V_STALL = 8'h00;
  localparam logic [7:0] V_EXC   = 8'hF8;
  localparam logic [7:0] V_EXCB  = 8'hF9;
  localparam logic [7:0] V_MFL   = 8'hE2;
`ifdef EXE_LOADUSE_STALL_EN
  localparam logic [7:0] V_LU    = 8'h28;
`else
  localparam logic [7:0] V_LU    = 8'hE0;
`endif

  typedef struct {
    logic [7:0] exp;
    string      name;
  } exp_t;

  exp_t sb_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  exe_issue_ctrl #(.DIV_CYCLES(32), .MUL_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .Exc_Flush(Exc_Flush), .MEM_Stall(MEM_Stall),
    .EXE_MDUReq(EXE_MDUReq), .EXE_MDUIsDiv(EXE_MDUIsDiv),
    .EXE_IsLoad(EXE_IsLoad), .EXE_rt(EXE_rt),
    .ID_rs(ID_rs), .ID_rt(ID_rt),
    .ID_ReadsRs(ID_ReadsRs), .ID_ReadsRt(ID_ReadsRt),
    .PC_Wr(PC_Wr), .ID_Wr(ID_Wr), .EXE_Wr(EXE_Wr),
    .ID_Flush(ID_Flush), .EXE_Flush(EXE_Flush),
    .MDU_Start(MDU_Start), .MDU_Flush(MDU_Flush), .MDU_Busy(MDU_Busy)
  );

  // Monitor: outputs are combinational, so every cycle presents a response.
  initial begin
    exp_t       e;
    logic [7:0] act;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e   = sb_q.pop_front();
        act = {PC_Wr, ID_Wr, EXE_Wr, ID_Flush, EXE_Flush, MDU_Start, MDU_Flush, MDU_Busy};
        vectors++;
        if (act !== e.exp) begin
          miscompares++;
          $display("FAIL %s: got %b required %b", e.name, act, e.exp);
        end else begin
          $display("ok   %s: %b", e.name, act);
        end
      end
    end
  end

  task automatic clr();
    Exc_Flush = 0; MEM_Stall = 0; EXE_MDUReq = 0; EXE_MDUIsDiv = 0; EXE_IsLoad = 0;
    EXE_rt = 0; ID_rs = 0; ID_rt = 0; ID_ReadsRs = 0; ID_ReadsRt = 0;
  endtask

  task automatic cyc(input logic [7:0] exp, input string name);
    exp_t e;
    e.exp  = exp;
    e.name = name;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    clr();
    @(posedge clk);
    #1;
    cyc(V_IDLE, "reset_state");
    rst = 1'b1;
    cyc(V_IDLE, "idle_after_reset");

    // Divide: start, 32 busy, DONE releases the stall without restarting.
    EXE_MDUReq = 1; EXE_MDUIsDiv = 1;
    cyc(V_START, "div_start");
    for (int i = 0; i < 32; i++) cyc(V_BUSY, $sformatf("div_busy_%0d", i));
    cyc(V_IDLE, "div_done_release");
    clr();
    cyc(V_IDLE, "div_no_restart");

    // Multiply with MEM_Stall held in DONE.
    EXE_MDUReq = 1;
    cyc(V_START, "mul_start");
    cyc(V_BUSY, "mul_busy_0");
    cyc(V_BUSY, "mul_busy_1");
    MEM_Stall = 1;
    for (int i = 0; i < 3; i++) cyc(V_STALL, $sformatf("mul_done_memstall_%0d", i));
    MEM_Stall = 0;
    cyc(V_IDLE, "mul_done_release");
    cyc(V_START, "mul_restart_from_idle");
    cyc(V_BUSY, "mul2_busy_0");
    MEM_Stall = 1;
    cyc(V_BUSY, "mul2_busy_memstall");
    cyc(V_STALL, "mul2_done_memstall");
    MEM_Stall = 0;
    cyc(V_IDLE, "mul2_done_release");
    clr();

    // Divide aborted by an exception at BUSY cycle 10.
    EXE_MDUReq = 1; EXE_MDUIsDiv = 1;
    cyc(V_START, "divx_start");
    for (int i = 0; i < 9; i++) cyc(V_BUSY, $sformatf("divx_busy_%0d", i));
    Exc_Flush = 1;
    cyc(V_EXCB, "divx_exc_in_busy");
    Exc_Flush = 0;
    cyc(V_MFL, "divx_mdu_flush_req_ignored");
    clr();
    cyc(V_IDLE, "divx_back_idle");

    // Exception versus a same-cycle request, and versus MEM_Stall.
    Exc_Flush = 1; EXE_MDUReq = 1;
    cyc(V_EXC, "exc_blocks_start");
    clr();
    cyc(V_IDLE, "exc_stays_idle");
    Exc_Flush = 1; MEM_Stall = 1;
    cyc(V_EXC, "exc_over_memstall");
    clr();
    MEM_Stall = 1;
    cyc(V_STALL, "memstall_only");
    clr();

    // Load-use hazard cases.
    EXE_IsLoad = 1; EXE_rt = 5; ID_rs = 5; ID_ReadsRs = 1;
    cyc(V_LU, "lu_rs_match");
    EXE_rt = 0; ID_rs = 0;
    cyc(V_IDLE, "lu_r0_never");
    EXE_rt = 5; ID_rs = 0; ID_ReadsRs = 0; ID_rt = 5; ID_ReadsRt = 1;
    cyc(V_LU, "lu_rt_match");
    ID_rt = 5; ID_ReadsRt = 0; ID_rs = 5; ID_ReadsRs = 0;
    cyc(V_IDLE, "lu_not_read");
    EXE_IsLoad = 0; ID_ReadsRs = 1;
    cyc(V_IDLE, "lu_not_load");
    EXE_IsLoad = 1; MEM_Stall = 1;
    cyc(V_STALL, "lu_under_memstall");
    MEM_Stall = 0; Exc_Flush = 1;
    cyc(V_EXC, "lu_under_exc");
    clr();

    // Reset asserted mid-BUSY returns to IDLE at once with no MDU_Flush.
    EXE_MDUReq = 1; EXE_MDUIsDiv = 1;
    cyc(V_START, "rstb_start");
    cyc(V_BUSY, "rstb_busy_0");
    cyc(V_BUSY, "rstb_busy_1");
    clr();
    rst = 1'b0;
    cyc(V_IDLE, "rst_mid_busy");
    rst = 1'b1;
    cyc(V_IDLE, "rst_no_mdu_flush");

    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
